// File: rtl/dong_ho_pkg.sv
// ---------------------------------------------------------------------------
// dong_ho_pkg
// Shared definitions for the BCD clock-counter family.
//   bcd_digit_t     : one packed BCD digit (4 bits)
//   BCD_MAX/BCD_MIN : legal digit range 0..9
//   MAX_DIGITS      : widest counter supported (6 digits)
//   bcd_to_bin()    : packed BCD (up to 6 digits) to binary, for range checks
//   bin_digit()     : decimal digit 'pos' of a binary constant
//   pow10()         : 10**n as an int, for parameter range checks
// ---------------------------------------------------------------------------
package dong_ho_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BCD_MIN    = 4'd0;
  localparam int         MAX_DIGITS = 6;
  localparam int         MAX_BITS   = 4 * MAX_DIGITS;

  // Digits above 9 still contribute their raw weight here; callers that
  // care about malformed digits check them separately.
  function automatic int bcd_to_bin(input logic [MAX_BITS-1:0] v);
    int acc;
    acc = 0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      acc = acc * 10 + int'(v[4*i +: 4]);
    end
    return acc;
  endfunction

  function automatic bcd_digit_t bin_digit(input int val, input int pos);
    int p;
    p = val;
    for (int i = 0; i < pos; i++) begin
      p = p / 10;
    end
    return bcd_digit_t'(p % 10);
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decimal digit of the counter. Priority on each rising edge:
// load > wrap > inc > dec > hold.
//   clk, rs_n  : clock, asynchronous active-low reset (digit -> 0)
//   load       : take load_val (already validated by the parent)
//   load_val   : digit value to load
//   wrap       : jump to wrap_to (terminal-count wrap of the whole counter)
//   wrap_to    : digit value used on wrap
//   inc, dec   : step up / step down by one (carry/borrow-in)
//   q          : current digit, registered
//   carry      : inc requested while q==9 (ripples into next digit)
//   borrow     : dec requested while q==0 (ripples into next digit)
// ---------------------------------------------------------------------------
module bcd_digit
  import dong_ho_pkg::*;
(
  input  logic       clk,
  input  logic       rs_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       wrap,
  input  logic [3:0] wrap_to,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  // Digit register: wrap beats stepping so that the terminal value of the
  // whole counter jumps in one edge instead of rippling digit by digit.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= load_val;
    end else if (wrap) begin
      q <= wrap_to;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  // Ripple signals are purely combinational so a multi-digit step settles
  // within the same cycle.
  assign carry  = inc & (q == BCD_MAX);
  assign borrow = dec & (q == BCD_MIN);

endmodule

// File: rtl/dem_bcd_mod.sv
// ---------------------------------------------------------------------------
// dem_bcd_mod
// Up/down BCD counter with programmable terminal count, synchronous load
// with range checking and a combinational terminal-count carry-out for
// cascading (e.g. seconds -> minutes -> hours).
// Parameters:
//   N_DIGIT  : number of BCD digits (1..6)
//   MAX_VAL  : terminal count in decimal (1 .. 10**N_DIGIT - 1)
// Ports:
//   clk      : clock, rising edge
//   rs_n     : asynchronous active-low reset (count -> 0, load_err -> 0)
//   en       : count enable / carry-in from a lower stage
//   up       : 1 = count up, 0 = count down
//   load     : synchronous load strobe (wins over en)
//   load_bcd : packed BCD load value, digit 0 in [3:0]
//   bcd      : current count, packed BCD, registered
//   tc       : en & (up ? count==MAX_VAL : count==0), combinational
//   load_err : one-cycle flag after a rejected load
// ---------------------------------------------------------------------------
module dem_bcd_mod
  import dong_ho_pkg::*;
#(
  parameter int N_DIGIT = 2,
  parameter int MAX_VAL = 23
) (
  input  logic                 clk,
  input  logic                 rs_n,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [4*N_DIGIT-1:0] load_bcd,
  output logic [4*N_DIGIT-1:0] bcd,
  output logic                 tc,
  output logic                 load_err
);

  localparam int W = 4 * N_DIGIT;

  // Reject illegal parameterisations at elaboration time.
  if (N_DIGIT < 1 || N_DIGIT > MAX_DIGITS) begin : g_bad_ndigit
    $error("dem_bcd_mod: N_DIGIT must be in 1..6");
  end
  if (MAX_VAL < 1 || MAX_VAL >= pow10(N_DIGIT)) begin : g_bad_maxval
    $error("dem_bcd_mod: MAX_VAL must be in 1 .. 10**N_DIGIT-1");
  end

  function automatic logic [W-1:0] max_bcd_calc();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIGIT; i++) begin
      r[4*i +: 4] = bin_digit(MAX_VAL, i);
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = max_bcd_calc();

  logic               at_max;
  logic               at_zero;
  logic               digits_ok;
  logic               load_ok;
  logic               do_load;
  logic               do_wrap;
  logic               step_up;
  logic               step_dn;
  logic [N_DIGIT:0]   inc_chain;
  logic [N_DIGIT:0]   dec_chain;
  logic [MAX_BITS-1:0] load_ext;
  logic               unused_top;

  assign at_max  = (bcd == MAX_BCD);
  assign at_zero = (bcd == '0);

  // Terminal count is a pure function of the present count and inputs so a
  // following stage sees it in the same cycle.
  assign tc = en & (up ? at_max : at_zero);

  // Load is accepted only when every digit is a real decimal digit and the
  // whole value does not exceed the terminal count.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < N_DIGIT; i++) begin
      if (load_bcd[4*i +: 4] > BCD_MAX) begin
        digits_ok = 1'b0;
      end
    end
  end

  assign load_ext = MAX_BITS'(load_bcd);
  assign load_ok  = digits_ok && (bcd_to_bin(load_ext) <= MAX_VAL);
  assign do_load  = load & load_ok;

  // Counting is suppressed by any load strobe, even a rejected one, so a
  // simultaneous en never leaks through.
  assign do_wrap = tc & ~load;
  assign step_up = en & ~load &  up & ~at_max;
  assign step_dn = en & ~load & ~up & ~at_zero;

  assign inc_chain[0] = step_up;
  assign dec_chain[0] = step_dn;

  for (genvar g = 0; g < N_DIGIT; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rs_n     (rs_n),
      .load     (do_load),
      .load_val (load_bcd[4*g +: 4]),
      .wrap     (do_wrap),
      .wrap_to  (up ? BCD_MIN : MAX_BCD[4*g +: 4]),
      .inc      (inc_chain[g]),
      .dec      (dec_chain[g]),
      .q        (bcd[4*g +: 4]),
      .carry    (inc_chain[g+1]),
      .borrow   (dec_chain[g+1])
    );
  end

  // The top digit never overflows because stepping stops at the terminal
  // value, so its ripple outputs are intentionally left unconnected.
  assign unused_top = inc_chain[N_DIGIT] | dec_chain[N_DIGIT];

  // Rejected-load flag: high for exactly the cycle after the bad strobe.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_dem_bcd_mod.sv
// ---------------------------------------------------------------------------
// tb_dem_bcd_mod
// Drives three counter configurations: a default 0..23 counter (sel 0), a
// 0..59 counter (sel 1) and a 59/59/23 cascade (sel 2). Expected outputs are
// queued with each stimulus and compared by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_dem_bcd_mod;

  typedef struct {
    int          sel;
    logic [23:0] bcd;
    logic        tc;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rs_n;

  logic        en_a, up_a, load_a;
  logic [7:0]  lb_a, bcd_a;
  logic        tc_a, err_a;

  logic        en_b, up_b, load_b;
  logic [7:0]  lb_b, bcd_b;
  logic        tc_b, err_b;

  logic        en_c, up_c, load_c;
  logic [23:0] lb_c, bcd_c;
  logic        tc_sec, tc_min, tc_hr;
  logic        err_sec, err_min, err_hr;

  exp_t        sb[$];
  string       sb_name[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  dem_bcd_mod u_a (
    .clk(clk), .rs_n(rs_n), .en(en_a), .up(up_a), .load(load_a),
    .load_bcd(lb_a), .bcd(bcd_a), .tc(tc_a), .load_err(err_a)
  );

  dem_bcd_mod #(.N_DIGIT(2), .MAX_VAL(59)) u_b (
    .clk(clk), .rs_n(rs_n), .en(en_b), .up(up_b), .load(load_b),
    .load_bcd(lb_b), .bcd(bcd_b), .tc(tc_b), .load_err(err_b)
  );

  dem_bcd_mod #(.N_DIGIT(2), .MAX_VAL(59)) u_sec (
    .clk(clk), .rs_n(rs_n), .en(en_c), .up(up_c), .load(load_c),
    .load_bcd(lb_c[7:0]), .bcd(bcd_c[7:0]), .tc(tc_sec), .load_err(err_sec)
  );

  dem_bcd_mod #(.N_DIGIT(2), .MAX_VAL(59)) u_min (
    .clk(clk), .rs_n(rs_n), .en(tc_sec), .up(up_c), .load(load_c),
    .load_bcd(lb_c[15:8]), .bcd(bcd_c[15:8]), .tc(tc_min), .load_err(err_min)
  );

  dem_bcd_mod #(.N_DIGIT(2), .MAX_VAL(23)) u_hr (
    .clk(clk), .rs_n(rs_n), .en(tc_min), .up(up_c), .load(load_c),
    .load_bcd(lb_c[23:16]), .bcd(bcd_c[23:16]), .tc(tc_hr), .load_err(err_hr)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] to_bcd(input int v);
    return 24'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic push_expect(input int sel, input logic [23:0] e_bcd,
                             input logic e_tc, input logic e_err,
                             input string nm);
    exp_t e;
    e.sel = sel;
    e.bcd = e_bcd;
    e.tc  = e_tc;
    e.err = e_err;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected at the following falling edge: bcd/err as left by the
  // previous edge, tc for the count and inputs now applied.
  task automatic applyStimulus(input int sel, input logic e, input logic u,
                               input logic l, input logic [23:0] lb,
                               input logic [23:0] e_bcd, input logic e_tc,
                               input logic e_err, input string nm);
    @(posedge clk);
    #1;
    case (sel)
      0: begin en_a = e; up_a = u; load_a = l; lb_a = lb[7:0]; end
      1: begin en_b = e; up_b = u; load_b = l; lb_b = lb[7:0]; end
      default: begin en_c = e; up_c = u; load_c = l; lb_c = lb; end
    endcase
    push_expect(sel, e_bcd, e_tc, e_err, nm);
  endtask

  task automatic compare_bit(input string nm, input string what,
                             input logic act, input logic req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s %s: actual %b required %b", nm, what, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    logic [23:0] a_bcd;
    logic        a_tc;
    logic        a_err;
    case (e.sel)
      0: begin a_bcd = {16'h0, bcd_a}; a_tc = tc_a; a_err = err_a; end
      1: begin a_bcd = {16'h0, bcd_b}; a_tc = tc_b; a_err = err_b; end
      default: begin
        a_bcd = bcd_c;
        a_tc  = tc_hr;
        a_err = err_sec | err_min | err_hr;
      end
    endcase
    n_assert++;
    if (a_bcd !== e.bcd) begin
      n_fail++;
      $display("[TB] FAIL %s bcd: actual %h required %h", nm, a_bcd, e.bcd);
    end
    compare_bit(nm, "tc", a_tc, e.tc);
    compare_bit(nm, "load_err", a_err, e.err);
  endtask

  // Monitor: consumes one queued expectation per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front(), sb_name.pop_front());
    end
  end

  initial begin
    rs_n = 1'b0;
    en_a = 0; up_a = 0; load_a = 0; lb_a = '0;
    en_b = 0; up_b = 0; load_b = 0; lb_b = '0;
    en_c = 0; up_c = 0; load_c = 0; lb_c = '0;
    $display("[TB] start");

    // Reset state and tc while held in reset.
    applyStimulus(0, 0, 0, 0, 24'h0, 24'h00, 0, 0, "reset_state");
    applyStimulus(0, 1, 0, 0, 24'h0, 24'h00, 1, 0, "reset_tc_down");
    applyStimulus(0, 0, 1, 0, 24'h0, 24'h00, 0, 0, "reset_tc_up");
    #2 rs_n = 1'b1;

    // Count up through the terminal value and wrap.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(0, 1, 1, 0, 24'h0, to_bcd(i), (i == 23), 0, "count_up");
    end
    applyStimulus(0, 0, 1, 0, 24'h0, 24'h00, 0, 0, "wrap_up");

    // Count down from zero: wrap to 23 then step down to 09.
    for (int j = 0; j < 16; j++) begin
      applyStimulus(0, 1, 0, 0, 24'h0, (j == 0) ? 24'h00 : to_bcd(24 - j),
                    (j == 0), 0, "count_down");
    end
    applyStimulus(0, 0, 0, 0, 24'h0, 24'h08, 0, 0, "hold");

    // Loads, load over enable, rejected loads and direction change.
    applyStimulus(0, 0, 0, 1, 24'h07, 24'h08, 0, 0, "load07");
    applyStimulus(0, 1, 1, 1, 24'h12, 24'h07, 0, 0, "load_with_en");
    applyStimulus(0, 0, 1, 0, 24'h0,  24'h12, 0, 0, "load_beats_en");
    applyStimulus(0, 0, 1, 1, 24'h24, 24'h12, 0, 0, "bad_load_a");
    applyStimulus(0, 0, 1, 0, 24'h0,  24'h12, 0, 1, "load_err_set");
    applyStimulus(0, 0, 1, 1, 24'h23, 24'h12, 0, 0, "load_err_clear");
    applyStimulus(0, 1, 1, 1, 24'h05, 24'h23, 1, 0, "tc_during_load");
    applyStimulus(0, 1, 1, 0, 24'h0,  24'h05, 0, 0, "loaded05");
    applyStimulus(0, 1, 0, 0, 24'h0,  24'h06, 0, 0, "dir_change");
    applyStimulus(0, 0, 0, 1, 24'h17, 24'h05, 0, 0, "down_applied");

    // 0..59 counter: good load, bad digit, out of range.
    applyStimulus(1, 0, 1, 1, 24'h45, 24'h00, 0, 0, "b_load45");
    applyStimulus(1, 0, 1, 1, 24'h4A, 24'h45, 0, 0, "b_loaded45");
    applyStimulus(1, 0, 1, 1, 24'h60, 24'h45, 0, 1, "b_reject_4a");
    applyStimulus(1, 0, 1, 0, 24'h0,  24'h45, 0, 1, "b_reject_60");
    applyStimulus(1, 1, 1, 0, 24'h0,  24'h45, 0, 0, "b_err_clear");
    applyStimulus(1, 0, 1, 0, 24'h0,  24'h46, 0, 0, "b_count");

    // Cascade 23:59:59 rolls to 00:00:00 in one edge, and back down.
    applyStimulus(2, 0, 1, 1, 24'h235959, 24'h000000, 0, 0, "c_load");
    applyStimulus(2, 1, 1, 0, 24'h0, 24'h235959, 1, 0, "c_loaded");
    applyStimulus(2, 0, 1, 0, 24'h0, 24'h000000, 0, 0, "c_wrap_up");
    applyStimulus(2, 1, 0, 0, 24'h0, 24'h000000, 1, 0, "c_at_zero");
    applyStimulus(2, 0, 0, 0, 24'h0, 24'h235959, 0, 0, "c_wrap_down");

    // Asynchronous reset mid-count with a pending load and increment.
    applyStimulus(0, 0, 0, 0, 24'h0, 24'h17, 0, 0, "pre_reset");
    @(posedge clk);
    #1;
    en_a = 1; up_a = 1; load_a = 1; lb_a = 8'h20;
    #1 rs_n = 1'b0;
    push_expect(0, 24'h00, 0, 0, "async_reset");
    @(posedge clk);
    #1;
    en_a = 0; load_a = 0;
    push_expect(0, 24'h00, 0, 0, "reset_discard");
    #1 rs_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 24'h0, 24'h00, 0, 0, "released");
    applyStimulus(0, 0, 1, 0, 24'h0, 24'h01, 0, 0, "first_count");

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL drain: actual %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dem_bcd_mod.md
DEM_BCD_MOD -- requirements
Module: dem_bcd_mod

Interface
REQ-001 Parameter N_DIGIT, default 2: number of BCD digits; legal range 1..6.
REQ-002 Parameter MAX_VAL, default 23: terminal count in decimal; must satisfy 1 <= MAX_VAL < 10^N_DIGIT, otherwise elaboration SHALL fail.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rs_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: count enable, doubles as carry-in from a lower stage.
REQ-006 Port up, input, 1: direction, 1 = increment, 0 = decrement.
REQ-007 Port load, input, 1: synchronous load strobe.
REQ-008 Port load_bcd, input, 4*N_DIGIT: value to load, packed BCD, digit 0 (units) in bits [3:0].
REQ-009 Port bcd, output, 4*N_DIGIT: current count, packed BCD, registered.
REQ-010 Port tc, output, 1: terminal-count carry-out, combinational, for cascading stages.
REQ-011 Port load_err, output, 1: registered one-cycle flag for a rejected load.

Function
REQ-012 Count value SHALL always lie in 0..MAX_VAL, with every digit in 0..9.
REQ-013 Priority per edge SHALL be load > en > hold.
REQ-014 With en=1, up=1 and count < MAX_VAL, count SHALL increment by 1 in decimal: the units digit 9 -> 0 carries into the next digit.
REQ-015 With en=1, up=1 and count == MAX_VAL, count SHALL wrap to 0.
REQ-016 With en=1, up=0 and count > 0, count SHALL decrement by 1 in decimal: the units digit 0 -> 9 borrows from the next digit.
REQ-017 With en=1, up=0 and count == 0, count SHALL wrap to MAX_VAL.
REQ-018 tc SHALL equal en AND (up ? count==MAX_VAL : count==0), evaluated in the same cycle, with no register stage.
REQ-019 With en=0 and load=0, count SHALL hold.
REQ-020 A load with all digits <= 9 and value <= MAX_VAL SHALL update bcd to load_bcd on that edge, with load_err=0 the next cycle.
REQ-021 A load with any digit > 9 or value > MAX_VAL SHALL leave the count unchanged and assert load_err for exactly one cycle after that edge.
REQ-022 load and en asserted together SHALL perform the load only, with no count in that cycle; tc still follows REQ-018 combinationally.
REQ-023 A change of up between edges SHALL take effect on the next enabled edge, with no extra latency.
REQ-024 Update latency SHALL be 1 clock from en/load sampling to bcd.

Reset
REQ-025 rs_n=0 SHALL immediately force bcd=0 and load_err=0, independent of clk.
REQ-026 tc during reset SHALL follow REQ-018 with count=0: it is 1 only if en=1 and up=0.
REQ-027 Reset release SHALL take effect at the first rising clk edge with rs_n=1; reset asserted mid-count SHALL discard any pending load or increment.

Structure
REQ-028 Shared package dong_ho_pkg SHALL hold the BCD digit typedef (4 bits), constants BCD_MAX=9 and BCD_MIN=0, and a function that converts packed BCD to binary for the MAX_VAL compare.
REQ-029 Sub-module bcd_digit SHALL implement one digit with inputs inc, dec and wrap_to (4 bits), and output carry/borrow-out; dem_bcd_mod SHALL instantiate N_DIGIT copies and add the MAX_VAL terminal-compare logic.
REQ-030 Stages SHALL cascade by connecting the tc of a lower stage to the en of the next stage, for example seconds (MAX_VAL=59) -> minutes (59) -> hours (23).

Verification
REQ-031 Defaults, up=1, en=1 held for 24 clocks from reset: bcd sequence 00,01,...,09,10,...,23,00; tc=1 only while bcd=23.
REQ-032 Defaults, up=0, en=1 from reset: bcd 00 -> 23 -> 22 ... -> 10 -> 09; tc=1 in the cycle bcd=00.
REQ-033 MAX_VAL=59: load_bcd=0x45 with load=1 -> bcd=45, load_err=0; then load_bcd=0x4A -> bcd stays 45, load_err=1 for one cycle; then load_bcd=0x60 -> rejected the same way.
REQ-034 load=1 and en=1 with load_bcd=0x12 while bcd=07 -> bcd=12, not 08 or 13.
REQ-035 Three cascaded stages (59/59/23) preloaded to 23:59:59, then one en pulse on the seconds stage -> all stages read 00:00:00 after a single edge.
REQ-036 rs_n pulled low between clock edges while bcd=17 -> bcd=00 immediately without a clock; the first count after release gives 01.
